// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl
//   Serial frame receiver that feeds a 2-entry output FIFO.
//   Frame (one bit per clk): start(1), 8 data bits LSB first, even parity,
//   stop1(0), stop2(0). Bad frames are dropped with a one-cycle error pulse.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   rxd           serial input, idle 0
//   en            start-detect enable (only gates IDLE->DATA)
//   data_out      FIFO head byte
//   data_valid    FIFO not empty
//   data_ready    consumer accept, pops on data_valid && data_ready
//   parity_err    pulse: frame dropped, bad parity
//   framing_err   pulse: frame dropped, stop bit was 1
//   overrun       pulse: good frame dropped, FIFO full
//   busy          receiver not in IDLE
//   frame_cnt     number of bytes pushed into the FIFO (wraps)
module rx_frame_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   input  logic       en,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overrun,
   output logic       busy,
   output logic [7:0] frame_cnt
);

   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;

   state_t     state;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       par_bad;
   logic       stop_bad;
   logic [7:0] fifo0;      // head entry, drives data_out directly
   logic [7:0] fifo1;
   logic [1:0] fifo_cnt;

   logic pop, stop_fail, push;

   assign data_out   = fifo0;
   assign data_valid = (fifo_cnt != 2'd0);
   assign busy       = (state != IDLE);

   assign pop       = data_valid && data_ready;
   // stop2 is being sampled right now; fold it into the frame verdict
   assign stop_fail = stop_bad | rxd;
   // A pop on the same edge frees a slot, so a full FIFO can still accept
   assign push      = (state == STOP2) && !stop_fail && !par_bad &&
                      ((fifo_cnt != 2'd2) || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= 3'd0;
         shreg       <= 8'h00;
         par_bad     <= 1'b0;
         stop_bad    <= 1'b0;
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
         fifo0       <= 8'h00;
         fifo1       <= 8'h00;
         fifo_cnt    <= 2'd0;
         frame_cnt   <= 8'd0;
      end else begin
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;

         case (state)
            IDLE: begin
               if (rxd && en) begin
                  state   <= DATA;
                  bit_cnt <= 3'd0;
               end
            end
            DATA: begin
               shreg[bit_cnt] <= rxd;
               bit_cnt        <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
               par_bad  <= (^shreg) ^ rxd;
               stop_bad <= 1'b0;
               state    <= STOP1;
            end
            STOP1: begin
               stop_bad <= rxd;
               state    <= STOP2;
            end
            STOP2: begin
               state <= IDLE;
               // framing beats parity; overrun only for otherwise good frames
               if (stop_fail)                        framing_err <= 1'b1;
               else if (par_bad)                     parity_err  <= 1'b1;
               else if (fifo_cnt == 2'd2 && !pop)    overrun     <= 1'b1;
            end
            default: state <= IDLE;
         endcase

         case ({push, pop})
            2'b10: begin
               if (fifo_cnt == 2'd0) fifo0 <= shreg;
               else                  fifo1 <= shreg;
               fifo_cnt <= fifo_cnt + 2'd1;
            end
            2'b01: begin
               fifo0    <= fifo1;
               fifo_cnt <= fifo_cnt - 2'd1;
            end
            2'b11: begin
               if (fifo_cnt == 2'd1) begin
                  fifo0 <= shreg;
               end else begin
                  fifo0 <= fifo1;
                  fifo1 <= shreg;
               end
            end
            default: ;
         endcase

         if (push) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl. Inputs change on the falling edge, the
// DUT samples on the rising edge, outputs are checked on falling edges.
module tb_rx_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd = 1'b0;
   logic       en = 1'b0;
   logic       data_ready = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       framing_err;
   logic       overrun;
   logic       busy;
   logic [7:0] frame_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rx_frame_ctrl dut (
      .clk(clk), .rst_n(rst_n), .rxd(rxd), .en(en),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .parity_err(parity_err), .framing_err(framing_err), .overrun(overrun),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; rxd = 1'b0; en = 1'b0; data_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
   endtask

   // Drives the 12 frame bits; returns right after the stop2 bit is driven.
   // drop_en_at >= 0 deasserts en right after that bit index.
   task automatic send_frame(input logic [7:0] d, input logic p,
                             input logic s1, input logic s2,
                             input int drop_en_at);
      logic [11:0] b;
      b = {s2, s1, p, d, 1'b1};
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rxd = b[i];
         if (i == drop_en_at) en = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests++;
      if ({data_valid, data_out, frame_cnt, busy, parity_err, framing_err, overrun} !== 21'd0) begin
         fails++;
         $display("FAIL reset_state: got valid=%b out=%h cnt=%0d busy=%b pe=%b fe=%b ov=%b required all zero",
                  data_valid, data_out, frame_cnt, busy, parity_err, framing_err, overrun);
      end
      do_reset();
   endtask

   task automatic test_good_frame();
      do_reset();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, -1);
      tests++;
      if (data_valid !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL good_latency_early: got valid=%b busy=%b required valid=0 busy=1", data_valid, busy);
      end
      @(negedge clk); rxd = 1'b0;
      tests++;
      if (data_valid !== 1'b1 || data_out !== 8'hA5 || frame_cnt !== 8'd1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL good_frame: got valid=%b out=%h cnt=%0d busy=%b required 1 a5 1 0",
                  data_valid, data_out, frame_cnt, busy);
      end
      tests++;
      if ({parity_err, framing_err, overrun} !== 3'b000) begin
         fails++;
         $display("FAIL good_no_err: got pe/fe/ov=%b required 000", {parity_err, framing_err, overrun});
      end
   endtask

   task automatic test_parity();
      do_reset();
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
      @(negedge clk); rxd = 1'b0;
      tests++;
      if (parity_err !== 1'b1 || framing_err !== 1'b0 || data_valid !== 1'b0 || frame_cnt !== 8'd0) begin
         fails++;
         $display("FAIL parity_pulse: got pe=%b fe=%b valid=%b cnt=%0d required 1 0 0 0",
                  parity_err, framing_err, data_valid, frame_cnt);
      end
      @(negedge clk);
      tests++;
      if (parity_err !== 1'b0 || data_valid !== 1'b0) begin
         fails++;
         $display("FAIL parity_one_cycle: got pe=%b valid=%b required 0 0", parity_err, data_valid);
      end
   endtask

   task automatic test_framing();
      do_reset();
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
      @(negedge clk); rxd = 1'b0;
      tests++;
      if (framing_err !== 1'b1 || parity_err !== 1'b0 || data_valid !== 1'b0 || frame_cnt !== 8'd0) begin
         fails++;
         $display("FAIL framing_priority: got fe=%b pe=%b valid=%b cnt=%0d required 1 0 0 0",
                  framing_err, parity_err, data_valid, frame_cnt);
      end
      // bad stop1 alone, parity good
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0, -1);
      @(negedge clk); rxd = 1'b0;
      tests++;
      if (framing_err !== 1'b1 || data_valid !== 1'b0) begin
         fails++;
         $display("FAIL framing_stop1: got fe=%b valid=%b required 1 0", framing_err, data_valid);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_frame(8'h01, 1'b1, 1'b0, 1'b0, -1);
      send_frame(8'h02, 1'b1, 1'b0, 1'b0, -1);
      send_frame(8'h03, 1'b0, 1'b0, 1'b0, -1);
      @(negedge clk); rxd = 1'b0;
      tests++;
      if (overrun !== 1'b1 || frame_cnt !== 8'd2 || data_valid !== 1'b1 || data_out !== 8'h01) begin
         fails++;
         $display("FAIL overrun: got ov=%b cnt=%0d valid=%b out=%h required 1 2 1 01",
                  overrun, frame_cnt, data_valid, data_out);
      end
      data_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (overrun !== 1'b0 || data_valid !== 1'b1 || data_out !== 8'h02) begin
         fails++;
         $display("FAIL pop_second: got ov=%b valid=%b out=%h required 0 1 02", overrun, data_valid, data_out);
      end
      @(negedge clk);
      tests++;
      if (data_valid !== 1'b0 || frame_cnt !== 8'd2) begin
         fails++;
         $display("FAIL pop_empty: got valid=%b cnt=%0d required 0 2", data_valid, frame_cnt);
      end
      data_ready = 1'b0;
   endtask

   task automatic test_push_pop_one();
      do_reset();
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, -1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, -1);
      data_ready = 1'b1;   // pop lands on the same edge as the push
      @(negedge clk); rxd = 1'b0; data_ready = 1'b0;
      tests++;
      if (data_valid !== 1'b1 || data_out !== 8'h22 || frame_cnt !== 8'd2 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL push_pop_one: got valid=%b out=%h cnt=%0d ov=%b required 1 22 2 0",
                  data_valid, data_out, frame_cnt, overrun);
      end
      data_ready = 1'b1;
      @(negedge clk); data_ready = 1'b0;
      tests++;
      if (data_valid !== 1'b0) begin
         fails++;
         $display("FAIL push_pop_occupancy: got valid=%b required 0", data_valid);
      end
   endtask

   task automatic test_push_pop_full();
      do_reset();
      send_frame(8'h44, 1'b0, 1'b0, 1'b0, -1);
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
      send_frame(8'h66, 1'b0, 1'b0, 1'b0, -1);
      data_ready = 1'b1;
      @(negedge clk); rxd = 1'b0; data_ready = 1'b0;
      tests++;
      if (overrun !== 1'b0 || data_out !== 8'h55 || frame_cnt !== 8'd3 || data_valid !== 1'b1) begin
         fails++;
         $display("FAIL push_pop_full: got ov=%b out=%h cnt=%0d valid=%b required 0 55 3 1",
                  overrun, data_out, frame_cnt, data_valid);
      end
      data_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (data_out !== 8'h66 || data_valid !== 1'b1) begin
         fails++;
         $display("FAIL push_pop_full_tail: got out=%h valid=%b required 66 1", data_out, data_valid);
      end
      @(negedge clk); data_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rxd = (i == 0) ? 1'b1 : 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b0; rxd = 1'b0;
      #1;
      tests++;
      if (busy !== 1'b0 || data_valid !== 1'b0 || frame_cnt !== 8'd0) begin
         fails++;
         $display("FAIL mid_reset: got busy=%b valid=%b cnt=%0d required 0 0 0", busy, data_valid, frame_cnt);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, -1);
      @(negedge clk); rxd = 1'b0;
      tests++;
      if (data_valid !== 1'b1 || data_out !== 8'h5A || frame_cnt !== 8'd1) begin
         fails++;
         $display("FAIL after_reset_frame: got valid=%b out=%h cnt=%0d required 1 5a 1",
                  data_valid, data_out, frame_cnt);
      end
   endtask

   task automatic test_enable();
      int bad;
      do_reset();
      en = 1'b0; bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rxd = 1'b1;
         if (busy !== 1'b0) bad++;
      end
      @(negedge clk); rxd = 1'b0;
      if (busy !== 1'b0) bad++;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL en_gate: busy high in %0d cycles, required 0", bad);
      end
      en = 1'b1;
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 2);
      @(negedge clk); rxd = 1'b0;
      tests++;
      if (data_valid !== 1'b1 || data_out !== 8'hFF || frame_cnt !== 8'd1 || en !== 1'b0) begin
         fails++;
         $display("FAIL en_midframe: got valid=%b out=%h cnt=%0d required 1 ff 1",
                  data_valid, data_out, frame_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity();
      test_framing();
      test_back_to_back();
      test_push_pop_one();
      test_push_pop_full();
      test_mid_reset();
      test_enable();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
